round_countdown_ctrl: RTL and testbench

// Round-time controller for the game datapath. Sequences the one-second timer

---
 rtl/round_countdown_ctrl.sv | 169 ++++++++++++++++
 tb/tb_round_countdown_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/round_countdown_ctrl.sv
// round_countdown_ctrl
// Round-time controller: sequences the one-second timer chain (enable plus a
// restart pulse), counts its 1 s ticks down from the round length and reports
// time remaining, expiry and round status to the game FSM and display logic.
//
// Optional feature: define ROUND_TIMER_WARN_EN to drive the low-time warning
// output. Without it, warn is present but held at 0 and no compare logic exists.
//
// All outputs come straight from flops. Inputs are resolved with the priority
// abort > answer_done > tick_1s > pause > start.

module round_countdown_ctrl #(
    parameter int ROUND_SECS = 20,
    parameter int SEC_W      = 5,
    parameter int WARN_SECS  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    input  logic             answer_done,
    input  logic             tick_1s,
    output logic             timer_enable,
    output logic             timer_clr,
    output logic [SEC_W-1:0] secs_left,
    output logic             time_up,
    output logic             round_over,
    output logic [2:0]       state,
    output logic             warn
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        PAUSE   = 3'd2,
        EXPIRED = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [SEC_W-1:0] RELOAD_SECS = SEC_W'(ROUND_SECS);
    localparam logic [SEC_W-1:0] ONE_SEC     = SEC_W'(1);
    localparam logic [SEC_W-1:0] ZERO_SECS   = SEC_W'(0);
`ifdef ROUND_TIMER_WARN_EN
    localparam logic [SEC_W-1:0] WARN_LVL    = SEC_W'(WARN_SECS);
`endif

    state_t           state_r;
    logic [SEC_W-1:0] secs_left_r;
    logic             timer_enable_r;
    logic             timer_clr_r;
    logic             time_up_r;
    logic             round_over_r;
    logic             warn_r;

    // Warning level for a counter value that is about to be loaded while the
    // round stays live (RUN or PAUSE); callers pass 0 for every other state.
    function automatic logic warn_calc(input logic [SEC_W-1:0] secs);
`ifdef ROUND_TIMER_WARN_EN
        return (secs != ZERO_SECS) && (secs <= WARN_LVL);
`else
        return (secs != secs);
`endif
    endfunction

    // Round sequencer: state, countdown and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= IDLE;
            secs_left_r    <= RELOAD_SECS;
            timer_enable_r <= 1'b0;
            timer_clr_r    <= 1'b0;
            time_up_r      <= 1'b0;
            round_over_r   <= 1'b0;
            warn_r         <= 1'b0;
        end else begin
            // Pulse outputs fall back to 0 unless a branch below re-asserts them.
            timer_clr_r <= 1'b0;
            time_up_r   <= 1'b0;

            if (abort) begin
                state_r        <= IDLE;
                secs_left_r    <= RELOAD_SECS;
                timer_enable_r <= 1'b0;
                round_over_r   <= 1'b0;
                warn_r         <= 1'b0;
            end else begin
                case (state_r)
                    IDLE, EXPIRED, DONE: begin
                        // Only start matters here; a new round reloads and
                        // restarts the timer chain from a clean phase.
                        if (start) begin
                            state_r        <= RUN;
                            secs_left_r    <= RELOAD_SECS;
                            timer_enable_r <= 1'b1;
                            timer_clr_r    <= 1'b1;
                            round_over_r   <= 1'b0;
                            warn_r         <= warn_calc(RELOAD_SECS);
                        end else begin
                            state_r <= state_r;
                        end
                    end

                    RUN: begin
                        if (answer_done) begin
                            // Answer wins over a coincident tick: time frozen.
                            state_r        <= DONE;
                            timer_enable_r <= 1'b0;
                            round_over_r   <= 1'b1;
                            warn_r         <= 1'b0;
                        end else if (tick_1s) begin
                            if (secs_left_r <= ONE_SEC) begin
                                // Last second consumed; expiry beats pause.
                                state_r        <= EXPIRED;
                                secs_left_r    <= ZERO_SECS;
                                timer_enable_r <= 1'b0;
                                time_up_r      <= 1'b1;
                                round_over_r   <= 1'b1;
                                warn_r         <= 1'b0;
                            end else begin
                                // Tick is counted before a coincident pause.
                                secs_left_r    <= secs_left_r - ONE_SEC;
                                state_r        <= pause ? PAUSE : RUN;
                                timer_enable_r <= ~pause;
                                warn_r         <= warn_calc(secs_left_r - ONE_SEC);
                            end
                        end else if (pause) begin
                            state_r        <= PAUSE;
                            timer_enable_r <= 1'b0;
                        end else begin
                            state_r <= RUN;
                        end
                    end

                    PAUSE: begin
                        if (answer_done) begin
                            state_r      <= DONE;
                            round_over_r <= 1'b1;
                            warn_r       <= 1'b0;
                        end else if (!pause) begin
                            // Resume without restarting the timer chain.
                            state_r        <= RUN;
                            timer_enable_r <= 1'b1;
                        end else begin
                            state_r <= PAUSE;
                        end
                    end

                    default: begin
                        state_r        <= IDLE;
                        secs_left_r    <= RELOAD_SECS;
                        timer_enable_r <= 1'b0;
                        round_over_r   <= 1'b0;
                        warn_r         <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign state        = state_r;
    assign secs_left    = secs_left_r;
    assign timer_enable = timer_enable_r;
    assign timer_clr    = timer_clr_r;
    assign time_up      = time_up_r;
    assign round_over   = round_over_r;
    assign warn         = warn_r;

endmodule

// File: tb/tb_round_countdown_ctrl.sv
// Directed bench for round_countdown_ctrl (ROUND_SECS=3, SEC_W=5, WARN_SECS=2).
// Observed outputs are packed as {state, secs_left, timer_enable, timer_clr,
// time_up, round_over, warn} and compared against hand-computed vectors.

module tb_round_countdown_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       pause;
    logic       abort;
    logic       answer_done;
    logic       tick_1s;
    logic       timer_enable;
    logic       timer_clr;
    logic [4:0] secs_left;
    logic       time_up;
    logic       round_over;
    logic [2:0] state;
    logic       warn;

    logic [12:0] obs;
    logic [12:0] exp_v;
    int          n_vec;
    int          n_err;

`ifdef ROUND_TIMER_WARN_EN
    localparam logic W = 1'b1;
`else
    localparam logic W = 1'b0;
`endif

    round_countdown_ctrl #(
        .ROUND_SECS (3),
        .SEC_W      (5),
        .WARN_SECS  (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .pause        (pause),
        .abort        (abort),
        .answer_done  (answer_done),
        .tick_1s      (tick_1s),
        .timer_enable (timer_enable),
        .timer_clr    (timer_clr),
        .secs_left    (secs_left),
        .time_up      (time_up),
        .round_over   (round_over),
        .state        (state),
        .warn         (warn)
    );

    assign obs = {state, secs_left, timer_enable, timer_clr, time_up, round_over, warn};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, let the edge happen, settle; pulses drop, pause holds.
    task automatic apply(input logic s, input logic p, input logic a,
                         input logic ad, input logic t);
        start       = s;
        pause       = p;
        abort       = a;
        answer_done = ad;
        tick_1s     = t;
        @(posedge clk);
        #1;
        start       = 1'b0;
        abort       = 1'b0;
        answer_done = 1'b0;
        tick_1s     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_v = {3'd0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        n_vec++;
        if (obs !== exp_v) begin $display("FAIL reset_state obs=%b exp=%b", obs, exp_v); n_err++; end
        rst = 1'b0;
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        exp_v = {3'd0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        n_vec++;
        if (obs !== exp_v) begin $display("FAIL idle_tick_ignored obs=%b exp=%b", obs, exp_v); n_err++; end
    endtask

    task automatic test_expiry();
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_v = {3'd1, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        n_vec++;
        if (obs !== exp_v) begin $display("FAIL exp_start obs=%b exp=%b", obs, exp_v); n_err++; end
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        exp_v = {3'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, W};
        n_vec++;
        if (obs !== exp_v) begin $display("FAIL exp_tick1 obs=%b exp=%b", obs, exp_v); n_err++; end
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        exp_v = {3'd1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, W};
        n_vec++;
        if (obs !== exp_v) begin $display("FAIL exp_tick2 obs=%b exp=%b", obs, exp_v); n_err++; end
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        exp_v = {3'd3, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        n_vec++;
        if (obs !== exp_v) begin $display("FAIL exp_tick3_expire obs=%b exp=%b", obs, exp_v); n_err++; end
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_v = {3'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        n_vec++;
        if (obs !== exp_v) begin $display("FAIL exp_time_up_one_cycle obs=%b exp=%b", obs, exp_v); n_err++; end
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_vec++;
        if (obs !== exp_v) begin $display("FAIL exp_tick4_no_change obs=%b exp=%b", obs, exp_v); n_err++; end
    endtask

    task automatic test_answer();
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_v = {3'd1, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        n_vec++;
        if (obs !== exp_v) begin $display("FAIL restart_from_expired obs=%b exp=%b", obs, exp_v); n_err++; end
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_v = {3'd1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        n_vec++;
        if (obs !== exp_v) begin $display("FAIL timer_clr_one_cycle obs=%b exp=%b", obs, exp_v); n_err++; end
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        exp_v = {3'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, W};
        n_vec++;
        if (obs !== exp_v) begin $display("FAIL ans_tick obs=%b exp=%b", obs, exp_v); n_err++; end
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        exp_v = {3'd4, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        n_vec++;
        if (obs !== exp_v) begin $display("FAIL ans_with_tick_done obs=%b exp=%b", obs, exp_v); n_err++; end
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_vec++;
        if (obs !== exp_v) begin $display("FAIL done_tick_ignored obs=%b exp=%b", obs, exp_v); n_err++; end
    endtask

    task automatic test_pause();
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_v = {3'd1, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        n_vec++;
        if (obs !== exp_v) begin $display("FAIL restart_from_done obs=%b exp=%b", obs, exp_v); n_err++; end
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_v = {3'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        n_vec++;
        if (obs !== exp_v) begin $display("FAIL pause_enter obs=%b exp=%b", obs, exp_v); n_err++; end
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
            n_vec++;
            if (obs !== exp_v) begin $display("FAIL pause_tick_%0d obs=%b exp=%b", i, obs, exp_v); n_err++; end
        end
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (obs !== exp_v) begin $display("FAIL pause_start_ignored obs=%b exp=%b", obs, exp_v); n_err++; end
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_v = {3'd1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        n_vec++;
        if (obs !== exp_v) begin $display("FAIL resume_no_clr obs=%b exp=%b", obs, exp_v); n_err++; end
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        exp_v = {3'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, W};
        n_vec++;
        if (obs !== exp_v) begin $display("FAIL resume_tick obs=%b exp=%b", obs, exp_v); n_err++; end
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        exp_v = {3'd2, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, W};
        n_vec++;
        if (obs !== exp_v) begin $display("FAIL pause_tick_counted obs=%b exp=%b", obs, exp_v); n_err++; end
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_v = {3'd1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, W};
        n_vec++;
        if (obs !== exp_v) begin $display("FAIL resume_at_one obs=%b exp=%b", obs, exp_v); n_err++; end
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        exp_v = {3'd3, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        n_vec++;
        if (obs !== exp_v) begin $display("FAIL pause_tick_expire obs=%b exp=%b", obs, exp_v); n_err++; end
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_v = {3'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        n_vec++;
        if (obs !== exp_v) begin $display("FAIL expired_hold obs=%b exp=%b", obs, exp_v); n_err++; end
    endtask

    task automatic test_abort();
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        exp_v = {3'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, W};
        n_vec++;
        if (obs !== exp_v) begin $display("FAIL abort_pre_tick obs=%b exp=%b", obs, exp_v); n_err++; end
        apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        exp_v = {3'd0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        n_vec++;
        if (obs !== exp_v) begin $display("FAIL abort_beats_answer obs=%b exp=%b", obs, exp_v); n_err++; end
        apply(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        n_vec++;
        if (obs !== exp_v) begin $display("FAIL idle_inputs_ignored obs=%b exp=%b", obs, exp_v); n_err++; end
        apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        n_vec++;
        if (obs !== exp_v) begin $display("FAIL abort_beats_start obs=%b exp=%b", obs, exp_v); n_err++; end
    endtask

    task automatic test_async_reset();
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        exp_v = {3'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, W};
        n_vec++;
        if (obs !== exp_v) begin $display("FAIL arst_pre obs=%b exp=%b", obs, exp_v); n_err++; end
        tick_1s = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        exp_v = {3'd0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        n_vec++;
        if (obs !== exp_v) begin $display("FAIL arst_immediate obs=%b exp=%b", obs, exp_v); n_err++; end
        @(posedge clk);
        #1;
        n_vec++;
        if (obs !== exp_v) begin $display("FAIL arst_held obs=%b exp=%b", obs, exp_v); n_err++; end
        tick_1s = 1'b0;
        rst     = 1'b0;
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (obs !== exp_v) begin $display("FAIL arst_release obs=%b exp=%b", obs, exp_v); n_err++; end
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        rst         = 1'b1;
        start       = 1'b0;
        pause       = 1'b0;
        abort       = 1'b0;
        answer_done = 1'b0;
        tick_1s     = 1'b0;
        test_reset();
        test_expiry();
        test_answer();
        test_pause();
        test_abort();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
